alu_seq_divider: RTL and testbench
==================================

// Module: alu_seq_divider
// PURPOSE
//  Sequential restoring divider: inverse datapath to the ALU multiplier. Computes quotient and remainder of
//  W=2*PART_LEN-bit operands, one quotient bit per cycle. Sits beside the ALU as its divide unit.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  PART_LEN  8  half-word width; operand/result width W = 2*PART_LEN
// PORTS
//  clk          in   1  clock, rising edge
//  rstn         in   1  reset, asynchronous, active-low
//  in_valid     in   1  a/b presented
//  in_ready     out  1  divider idle, will accept
//  a            in   W  dividend
//  b            in   W  divisor
//  out_valid    out  1  quot/rem/div_by_zero valid
//  out_ready    in   1  consumer takes result
//  quot         out  W  quotient
//  rem          out  W  remainder
//  div_by_zero  out  1  b was zero for this result
// BEHAVIOUR
//  - Reset (async, rstn=0): state IDLE; in_ready=0 while rstn=0, then 1; out_valid=0; quot=rem=0; div_by_zero=0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
//  - Accept on the rising edge with in_valid&&in_ready (edge T): latch a,b; clear partial remainder; counter=W-1.
//  - BUSY: each edge shifts {prem,dividend} left 1; trial subtract prem-b (W+1 bits);
//    if non-negative keep difference, shift in quotient bit 1, else 0. Counter decrements.
//    After the counter=0 iteration (edge T+W): register quot/rem, go DONE. out_valid is high from edge T+W.
//  - Divide by zero (b==0 at accept): skip BUSY. DONE at edge T itself.
//    quot=all ones, rem=a, div_by_zero=1.
//  - DONE: quot/rem/div_by_zero stable while out_valid&&!out_ready. On out_valid&&out_ready edge -> IDLE.
//    No accept in that same cycle; in_ready is high on the next cycle.
//  - quot/rem/div_by_zero update only on DONE entry and otherwise hold the last result (incl. through IDLE/BUSY).
//  - in_valid in BUSY/DONE is ignored; a/b need not be held after accept.
//  - rstn low mid-BUSY/DONE: abort immediately, all outputs to reset values, result discarded.
//  - Identities: a<b -> quot=0, rem=a. a==b (b!=0) -> quot=1, rem=0.
// CONFIGURATION
//  ALU_DIV_SIGNED_EN defined:
//    - Operands are two's complement. Divide |a|/|b| unsigned on the same W-cycle schedule.
//    - quot negated iff sign(a)^sign(b); rem takes sign of a (truncation toward zero).
//    - -2^(W-1)/-1 -> quot=-2^(W-1) (wrap), rem=0, no flag.
//    - b==0 -> quot=all ones, rem=a, div_by_zero=1.
//    - Latency unchanged (abs/negate are combinational at load/finish).
//  Undefined: operands and results are unsigned only; no sign logic synthesized.
// STRUCTURE
//  - Shared package alu_pkg:
//    - PART_LEN default;
//    - ALU op constants OPP_ASN=0, OPP_MUL=1, OPP_DIV=2;
//    - divider state typedef {DIV_IDLE, DIV_BUSY, DIV_DONE}.
//  - One sub-module alu_div_step: combinational single restoring iteration
//    (prem, dividend msb, b) -> (next prem, quotient bit).
//  - FSM, counter ($clog2(W) bits) and handshake live in the top.
// TESTING (PART_LEN=8, W=16)
//  1. a=100,b=7 -> quot=14, rem=2, div_by_zero=0; out_valid high exactly 16 cycles after accept edge.
//  2. a=16'hFFFF,b=1 -> quot=16'hFFFF, rem=0; a=5,b=9 -> quot=0, rem=5.
//  3. a=1234,b=0 -> div_by_zero=1, quot=16'hFFFF, rem=1234; out_valid high cycle after accept.
//  4. out_ready=0 for 5 cycles in DONE -> out_valid, quot, rem stable and in_ready=0; in_valid ignored;
//     then out_ready=1 -> next op accepted one cycle later.
//  5. rstn pulsed low during BUSY iteration 8 -> outputs zero at once; after release in_ready=1,
//     a fresh 100/7 yields 14 r 2.
//  6. ALU_DIV_SIGNED_EN:
//     - -100/7 -> quot=16'hFFF2, rem=16'hFFFE;
//     - 16'h8000/16'hFFFF -> quot=16'h8000, rem=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: default half-word width, ALU op codes and divider FSM states.
package alu_pkg;

  localparam int PART_LEN_DFLT = 8;

  localparam logic [1:0] OPP_ASN = 2'd0;
  localparam logic [1:0] OPP_MUL = 2'd1;
  localparam logic [1:0] OPP_DIV = 2'd2;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module alu_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_prem,
  input  logic         i_msb,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_prem,
  output logic         o_qbit
);

  logic [W:0]   w_sh;
  logic [W+1:0] w_diff;

  assign w_sh   = {i_prem, i_msb};
  assign w_diff = {1'b0, w_sh} - {2'b00, i_dvs};
  assign o_qbit = ~w_diff[W+1];
  // prem < divisor on entry, so a kept difference always fits in W bits
  assign o_prem = o_qbit ? w_diff[W-1:0] : w_sh[W-1:0];

endmodule

// File: rtl/alu_seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define ALU_DIV_SIGNED_EN for two's-complement operands (truncating division).
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int PART_LEN = PART_LEN_DFLT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*PART_LEN-1:0]   a,
  input  logic [2*PART_LEN-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*PART_LEN-1:0]   quot,
  output logic [2*PART_LEN-1:0]   rem,
  output logic                    div_by_zero
);

  localparam int W  = 2 * PART_LEN;
  localparam int CW = $clog2(W);

  div_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_prem, r_dvd, r_dvs;
  logic [W-1:0]  r_quot, r_rem;
  logic          r_dbz;

  logic [W-1:0]  w_prem_nxt, w_quot_raw;
  logic [W-1:0]  w_a_mag, w_b_mag, w_quot_fin, w_rem_fin;
  logic          w_qbit;

  alu_div_step #(.W(W)) u_step (
    .i_prem (r_prem),
    .i_msb  (r_dvd[W-1]),
    .i_dvs  (r_dvs),
    .o_prem (w_prem_nxt),
    .o_qbit (w_qbit)
  );

  // quotient bits shift into the vacated low end of the dividend register
  assign w_quot_raw = {r_dvd[W-2:0], w_qbit};

`ifdef ALU_DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;

  assign w_a_mag    = a[W-1] ? (~a + 1'b1) : a;
  assign w_b_mag    = b[W-1] ? (~b + 1'b1) : b;
  assign w_quot_fin = r_neg_q ? (~w_quot_raw + 1'b1) : w_quot_raw;
  assign w_rem_fin  = r_neg_r ? (~w_prem_nxt + 1'b1) : w_prem_nxt;
`else
  assign w_a_mag    = a;
  assign w_b_mag    = b;
  assign w_quot_fin = w_quot_raw;
  assign w_rem_fin  = w_prem_nxt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_prem  <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (in_valid) begin
            if (b == '0) begin
              r_quot  <= '1;
              r_rem   <= a;
              r_dbz   <= 1'b1;
              r_state <= DIV_DONE;
            end else begin
              r_dvd   <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_prem  <= '0;
              r_cnt   <= CW'(W - 1);
              r_state <= DIV_BUSY;
`ifdef ALU_DIV_SIGNED_EN
              r_neg_q <= a[W-1] ^ b[W-1];
              r_neg_r <= a[W-1];
`endif
            end
          end
        end
        DIV_BUSY: begin
          r_prem <= w_prem_nxt;
          r_dvd  <= w_quot_raw;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quot  <= w_quot_fin;
            r_rem   <= w_rem_fin;
            r_dbz   <= 1'b0;
            r_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (out_ready) r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  // gate with rstn so in_ready stays low for the whole reset pulse
  assign in_ready    = rstn && (r_state == DIV_IDLE);
  assign out_valid   = (r_state == DIV_DONE);
  assign quot        = r_quot;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Bench for alu_seq_divider: timeline model checked every cycle plus directed literal checks.
module tb_alu_seq_divider;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, out_ready;
  logic          in_ready, out_valid, div_by_zero;
  logic [W-1:0]  a, b, quot, rem;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 0;

  always #5 clk = ~clk;

  alu_seq_divider #(.PART_LEN(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain / and % on the operand values.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] ra, input logic [W-1:0] rb);
    logic [W-1:0] q, r;
    if (rb == '0) begin
      q = '1;
      r = ra;
      return {1'b1, q, r};
    end
`ifdef ALU_DIV_SIGNED_EN
    begin
      logic signed [W-1:0] sa, sb;
      int ia, ib;
      sa = ra; sb = rb;
      ia = int'(sa); ib = int'(sb);
      q = W'(ia / ib);
      r = W'(ia % ib);
    end
`else
    q = ra / rb;
    r = ra % rb;
`endif
    return {1'b0, q, r};
  endfunction

  // Timeline model: an accepted op publishes its result after a fixed latency
  // and is retired by the first out_ready edge after publication.
  int           m_cyc = 0;
  int           m_due = 0;
  bit           m_busy = 0;
  logic [2*W:0] m_res;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic         m_z = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0;
      m_q = '0; m_r = '0; m_z = 1'b0;
    end else begin
      m_cyc++;
      if (m_busy && m_cyc > m_due && out_ready) m_busy = 0;
      else if (!m_busy && in_valid) begin
        m_res  = ref_div(a, b);
        m_due  = m_cyc + ((b == '0) ? 0 : W);
        m_busy = 1;
      end
      if (m_busy && m_cyc == m_due) begin
        m_z = m_res[2*W];
        m_q = m_res[2*W-1:W];
        m_r = m_res[W-1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mdl_in_ready",  {31'd0, in_ready},    {31'd0, rstn && !m_busy});
      chk("mdl_out_valid", {31'd0, out_valid},   {31'd0, rstn && m_busy && m_cyc >= m_due});
      chk("mdl_quot",      {16'd0, quot},        {16'd0, m_q});
      chk("mdl_rem",       {16'd0, rem},         {16'd0, m_r});
      chk("mdl_dbz",       {31'd0, div_by_zero}, {31'd0, m_z});
    end
  end

  // Waits (bounded) for out_valid; returns cycles since the accept edge or -1.
  task automatic wait_result(output int lat);
    lat = -1;
    if (out_valid) lat = 0;
    else begin
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (out_valid) begin lat = k; break; end
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int elat);
    int lat;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    wait_result(lat);
    chk({name, "_lat"},  lat, elat);
    chk({name, "_quot"}, {16'd0, quot}, {16'd0, eq});
    chk({name, "_rem"},  {16'd0, rem},  {16'd0, er});
    chk({name, "_dbz"},  {31'd0, div_by_zero}, {31'd0, ez});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_retired"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_in_ready",  {31'd0, in_ready},    32'd0);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_quot",      {16'd0, quot},        32'd0);
    chk("rst_rem",       {16'd0, rem},         32'd0);
    chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    #9 rstn = 1'b1;
    started = 1;
    @(posedge clk); #1;

    run_op("d100_7",  16'd100,  16'd7, 16'd14,    16'd2,    1'b0, 16);
    run_op("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF,  16'd0,    1'b0, 16);
    run_op("d5_9",    16'd5,    16'd9, 16'd0,     16'd5,    1'b0, 16);
    run_op("d77_77",  16'd77,   16'd77, 16'd1,    16'd0,    1'b0, 16);
    run_op("d1234_0", 16'd1234, 16'd0, 16'hFFFF,  16'd1234, 1'b1, 0);
    run_op("d7_2",    16'd7,    16'd2, 16'd3,     16'd1,    1'b0, 16);

    // Back-pressure: result held, new request ignored until one cycle after retire.
    a = 16'd200; b = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp_lat", lat, 16);
    a = 16'd50; b = 16'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",    {31'd0, out_valid}, 32'd1);
      chk("bp_quot",     {16'd0, quot},      32'd66);
      chk("bp_rem",      {16'd0, rem},       32'd2);
      chk("bp_in_ready", {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", {31'd0, in_ready},  32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", {31'd0, in_ready}, 32'd0);
    wait_result(lat);
    chk("bp2_lat",  lat, 16);
    chk("bp2_quot", {16'd0, quot}, 32'd10);
    chk("bp2_rem",  {16'd0, rem},  32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset abort mid-iteration.
    a = 16'd999; b = 16'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("abort_quot",     {16'd0, quot},      32'd0);
    chk("abort_rem",      {16'd0, rem},       32'd0);
    chk("abort_valid",    {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready},  32'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);

`ifdef ALU_DIV_SIGNED_EN
    run_op("s_m100_7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 16);
    run_op("s_min_m1",   16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 16);
    run_op("s_100_m7",   16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 16);
    run_op("s_m5_0",     16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1, 0);
`else
    run_op("u_8000_ffff", 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 16);
    run_op("u_fff0_10",   16'hFFF0, 16'd16,   16'h0FFF, 16'd0,    1'b0, 16);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
